sysbus_arbiter_rr: RTL and testbench
====================================

// Module: sysbus_arbiter_rr
// PURPOSE
//  Parametrised N-master arbiter for the shared sysbus. It replaces the fixed
//  2-port arbiter and adds selectable fixed-priority or round-robin modes.
//  A hold limit stops a master that always requests (the CPU holds req high)
//  from starving DMA-style masters such as the APU sample fetcher.
//  It owns sel[] (drives the addr/we muxes) and per-master rdy gating.
// PARAMETERS
//  N        4   number of bus masters, 2..8
//  MODE     1   0 = fixed priority (index 0 highest); 1 = round-robin
//  MAXHOLD  8   max consecutive completed transfers for one owner while another
//               master requests; 0 = unlimited
//  PARK     0   master index granted when nobody requests, 0..N-1
// PORTS
//  clk      in   1          system clock (sys.clk)
//  n_reset  in   1          asynchronous, active-low reset
//  req      in   N          per-master bus request, level
//  ifrdy    in   1          slave-side ready for current transfer
//  sel      out  N          one-hot grant, registered
//  rdy      out  N          rdy[i] = sel[i] & ifrdy (combinational)
//  gnt_id   out  clog2(N)   binary index of sel, registered
//  busy     out  1          1 when owner's req is high, registered
// BEHAVIOUR
//  Reset (async, n_reset=0): sel=one-hot(PARK), gnt_id=PARK, busy=0,
//   hold_cnt=0, rr_ptr=PARK. Takes effect immediately, even mid-transfer.
//   Outputs stay valid throughout reset.
//  Arbitration on each posedge clk, only when ifrdy=1. Grant is frozen while
//   ifrdy=0, so a wait-stated transfer never loses its master.
//  Rearbitrate when either condition holds:
//   (a) owner req=0
//   (b) MAXHOLD!=0, hold_cnt==MAXHOLD-1, another req is high
//  Otherwise keep the owner and increment hold_cnt. hold_cnt saturates at
//   MAXHOLD-1. It clears to 0 whenever the owner changes.
//  Winner selection:
//   MODE=0: lowest index with req=1.
//   MODE=1: first req=1 searching from rr_ptr+1 upward, wrapping N-1 -> 0.
//    rr_ptr <= winner on every grant change.
//   Case (b): the current owner is excluded from the search.
//  No req high: sel=one-hot(PARK), busy=0. The parked master may start a
//   transfer with 0 added latency.
//  Latency: a req rising on an idle, non-parked bus gives sel at the next
//   edge (1 cycle).
//  Owner drops req and another requests in the same cycle: handoff at that
//   edge, with no idle cycle.
//  N=1 degenerate is not supported. Elaborate-time error if N<2 or PARK>=N.
//  Invariant: sel is exactly one-hot at all times.
//  Invariant: gnt_id == index of sel.
//  Invariant: rdy is nonzero only on the sel bit.
// TESTING
//  1 Reset: N=4,PARK=0, assert n_reset=0 mid-grant of master 2 ->
//    sel=4'b0001, gnt_id=0, busy=0 asynchronously.
//  2 RR fairness: MODE=1, req=4'b1111, ifrdy=1, MAXHOLD=1 -> grant
//    sequence 1,2,3,0,1... one per cycle.
//  3 Starvation guard: req[0]=1 constantly, req[1] rises at cycle 3,
//    MAXHOLD=8 -> sel moves to 1 after master 0's 8th completed transfer.
//    It returns to 0 when req[1] drops.
//  4 Wait states: owner 2, ifrdy=0 for 5 cycles with req[3]=1 -> sel stays
//    4'b0100. It switches only at the first edge with ifrdy=1 after the
//    limit is met.
//  5 Fixed priority: MODE=0, MAXHOLD=0, req=4'b1010 -> sel=4'b0010.
//    req[0] rises -> sel=4'b0001 next edge. Master 3 never granted while
//    req[0] or req[1] is high.
//  6 Simultaneous drop: owner 1 drops req in the same cycle req[2] rises ->
//    sel=4'b0100 next edge, busy=1, no parked cycle inserted.

Source files
------------

// File: rtl/sysbus_arbiter_rr.sv
// sysbus_arbiter_rr: N-master sysbus arbiter, fixed-priority or round-robin,
// with a hold limit so an always-requesting master cannot starve the others.
// Ports:
//   clk      system clock
//   n_reset  asynchronous active-low reset
//   req      per-master level request
//   ifrdy    slave ready for the current transfer
//   sel      registered one-hot grant (drives addr/we muxes)
//   rdy      per-master ready, sel gated by ifrdy
//   gnt_id   registered binary index of sel
//   busy     registered, 1 while the owner is requesting
module sysbus_arbiter_rr #(
    parameter int N       = 4,
    parameter int MODE    = 1,
    parameter int MAXHOLD = 8,
    parameter int PARK    = 0
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic [N-1:0]         req,
    input  logic                 ifrdy,
    output logic [N-1:0]         sel,
    output logic [N-1:0]         rdy,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy
);

    localparam int IW = $clog2(N);
    localparam int HW = (MAXHOLD > 1) ? $clog2(MAXHOLD) : 1;

    localparam logic [N-1:0]  ONE_OH   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]  PARK_OH  = ONE_OH << PARK;
    localparam logic [IW-1:0] PARK_ID  = IW'(PARK);
    localparam logic [HW-1:0] HOLD_MAX = (MAXHOLD > 0) ? HW'(MAXHOLD - 1) : '0;

    if (N < 2 || N > 8) begin : g_bad_n
        $error("sysbus_arbiter_rr: N must be in 2..8");
    end
    if (PARK < 0 || PARK >= N) begin : g_bad_park
        $error("sysbus_arbiter_rr: PARK must be in 0..N-1");
    end
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
        $error("sysbus_arbiter_rr: MODE must be 0 or 1");
    end
    if (MAXHOLD < 0) begin : g_bad_hold
        $error("sysbus_arbiter_rr: MAXHOLD must be >= 0");
    end

    logic [N-1:0]  sel_q, sel_d;
    logic [IW-1:0] gnt_id_q, gnt_id_d;
    logic          busy_q, busy_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;

    logic          owner_req;
    logic          other_req;
    logic          lower_req;
    logic          limit_hit;
    logic          rearb;
    logic [N-1:0]  cand;
    logic          win_found;
    logic [IW-1:0] win_id;
    logic [IW-1:0] idx;

    assign owner_req = |(req & sel_q);
    assign other_req = |(req & ~sel_q);

    // Hold limit reached while someone else is waiting.
    assign limit_hit = (MAXHOLD != 0) && (hold_cnt_q == HOLD_MAX) && other_req;

    // In fixed-priority mode a request from a lower index preempts the
    // owner at the next completed transfer.
    always_comb begin
        lower_req = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i < int'(gnt_id_q) && req[i]) begin
                lower_req = 1'b1;
            end
        end
    end

    assign rearb = !owner_req || limit_hit || ((MODE == 0) && lower_req);

    // The owner is never a candidate: either it dropped req, it hit the
    // hold limit, or a higher-priority master beats it anyway.
    assign cand = req & ~sel_q;

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        if (MODE == 0) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (cand[i]) begin
                    win_found = 1'b1;
                    win_id    = IW'(i);
                end
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                idx = IW'((int'(rr_ptr_q) + k) % N);
                if (!win_found && cand[idx]) begin
                    win_found = 1'b1;
                    win_id    = idx;
                end
            end
        end
    end

    always_comb begin
        sel_d      = sel_q;
        gnt_id_d   = gnt_id_q;
        busy_d     = busy_q;
        hold_cnt_d = hold_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        // Grant only moves on a completed transfer; wait states freeze it.
        if (ifrdy) begin
            if (rearb) begin
                hold_cnt_d = '0;
                if (win_found) begin
                    sel_d    = ONE_OH << win_id;
                    gnt_id_d = win_id;
                    busy_d   = 1'b1;
                    rr_ptr_d = win_id;
                end else begin
                    sel_d    = PARK_OH;
                    gnt_id_d = PARK_ID;
                    busy_d   = 1'b0;
                end
            end else begin
                busy_d = 1'b1;
                if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sel_q      <= PARK_OH;
            gnt_id_q   <= PARK_ID;
            busy_q     <= 1'b0;
            hold_cnt_q <= '0;
            rr_ptr_q   <= PARK_ID;
        end else begin
            sel_q      <= sel_d;
            gnt_id_q   <= gnt_id_d;
            busy_q     <= busy_d;
            hold_cnt_q <= hold_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign sel    = sel_q;
    assign gnt_id = gnt_id_q;
    assign busy   = busy_q;
    assign rdy    = sel_q & {N{ifrdy}};

endmodule

// File: tb/tb_sysbus_arbiter_rr.sv
// tb_sysbus_arbiter_rr: directed bench for sysbus_arbiter_rr.
// Three instances: round-robin/hold 1, round-robin/hold 8, fixed/unlimited.
module tb_sysbus_arbiter_rr;

    logic       clk;
    logic       n_reset;

    logic [3:0] req_a, req_b, req_c;
    logic       ifrdy_a, ifrdy_b, ifrdy_c;
    logic [3:0] sel_a, sel_b, sel_c;
    logic [3:0] rdy_a, rdy_b, rdy_c;
    logic [1:0] gid_a, gid_b, gid_c;
    logic       busy_a, busy_b, busy_c;

    int errors = 0;
    int checks = 0;

    sysbus_arbiter_rr #(.N(4), .MODE(1), .MAXHOLD(1), .PARK(0)) u_rr1 (
        .clk(clk), .n_reset(n_reset), .req(req_a), .ifrdy(ifrdy_a),
        .sel(sel_a), .rdy(rdy_a), .gnt_id(gid_a), .busy(busy_a)
    );

    sysbus_arbiter_rr #(.N(4), .MODE(1), .MAXHOLD(8), .PARK(0)) u_rr8 (
        .clk(clk), .n_reset(n_reset), .req(req_b), .ifrdy(ifrdy_b),
        .sel(sel_b), .rdy(rdy_b), .gnt_id(gid_b), .busy(busy_b)
    );

    sysbus_arbiter_rr #(.N(4), .MODE(0), .MAXHOLD(0), .PARK(0)) u_fp (
        .clk(clk), .n_reset(n_reset), .req(req_c), .ifrdy(ifrdy_c),
        .sel(sel_c), .rdy(rdy_c), .gnt_id(gid_c), .busy(busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_a = '0; req_b = '0; req_c = '0;
        ifrdy_a = 1'b1; ifrdy_b = 1'b1; ifrdy_c = 1'b1;
        @(negedge clk);
        n_reset = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (sel_b !== 4'b0001 || gid_b !== 2'd0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: sel=%b gid=%0d busy=%b want 0001/0/0",
                     sel_b, gid_b, busy_b);
        end
        req_b = 4'b0100;
        tick();
        checks++;
        if (sel_b !== 4'b0100 || gid_b !== 2'd2 || busy_b !== 1'b1) begin
            errors++;
            $display("FAIL reset_pregrant: sel=%b gid=%0d busy=%b want 0100/2/1",
                     sel_b, gid_b, busy_b);
        end
        #2;
        n_reset = 1'b0;
        #1;
        checks++;
        if (sel_b !== 4'b0001 || gid_b !== 2'd0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: sel=%b gid=%0d busy=%b want 0001/0/0",
                     sel_b, gid_b, busy_b);
        end
        checks++;
        if (rdy_b !== 4'b0001) begin
            errors++;
            $display("FAIL reset_rdy: rdy=%b want 0001", rdy_b);
        end
        tick();
        checks++;
        if (sel_b !== 4'b0001 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: sel=%b busy=%b want 0001/0", sel_b, busy_b);
        end
        @(negedge clk);
        n_reset = 1'b1;
        req_b = '0;
    endtask

    task automatic test_rr_fairness();
        int exp_seq [8];
        logic [3:0] one;
        logic [3:0] exp_sel;
        exp_seq = '{1, 2, 3, 0, 1, 2, 3, 0};
        one = 4'b0001;
        do_reset();
        req_a = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_sel = one << exp_seq[i];
            checks++;
            if (gid_a !== 2'(exp_seq[i]) || sel_a !== exp_sel) begin
                errors++;
                $display("FAIL rr_seq[%0d]: gid=%0d sel=%b want %0d/%b",
                         i, gid_a, sel_a, exp_seq[i], exp_sel);
            end
        end
        req_a = '0;
    endtask

    task automatic test_starvation();
        do_reset();
        req_b = 4'b0001;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (sel_b !== 4'b0001 || busy_b !== 1'b1) begin
            errors++;
            $display("FAIL starve_own0: sel=%b busy=%b want 0001/1", sel_b, busy_b);
        end
        req_b = 4'b0011;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (sel_b !== 4'b0001) begin
            errors++;
            $display("FAIL starve_before_limit: sel=%b want 0001", sel_b);
        end
        tick();
        checks++;
        if (sel_b !== 4'b0010 || gid_b !== 2'd1 || busy_b !== 1'b1) begin
            errors++;
            $display("FAIL starve_switch: sel=%b gid=%0d busy=%b want 0010/1/1",
                     sel_b, gid_b, busy_b);
        end
        req_b = 4'b0001;
        tick();
        checks++;
        if (sel_b !== 4'b0001 || gid_b !== 2'd0) begin
            errors++;
            $display("FAIL starve_return: sel=%b gid=%0d want 0001/0", sel_b, gid_b);
        end
        req_b = '0;
    endtask

    task automatic test_wait_states();
        do_reset();
        req_b = 4'b0100;
        tick();
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (sel_b !== 4'b0100) begin
            errors++;
            $display("FAIL wait_owner: sel=%b want 0100", sel_b);
        end
        req_b = 4'b1100;
        ifrdy_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (sel_b !== 4'b0100 || rdy_b !== 4'b0000) begin
                errors++;
                $display("FAIL wait_frozen[%0d]: sel=%b rdy=%b want 0100/0000",
                         i, sel_b, rdy_b);
            end
        end
        ifrdy_b = 1'b1;
        #1;
        checks++;
        if (rdy_b !== 4'b0100) begin
            errors++;
            $display("FAIL wait_rdy: rdy=%b want 0100", rdy_b);
        end
        tick();
        checks++;
        if (sel_b !== 4'b1000 || gid_b !== 2'd3) begin
            errors++;
            $display("FAIL wait_switch: sel=%b gid=%0d want 1000/3", sel_b, gid_b);
        end
        req_b = '0;
    endtask

    task automatic test_fixed_priority();
        do_reset();
        req_c = 4'b1010;
        tick();
        checks++;
        if (sel_c !== 4'b0010 || gid_c !== 2'd1) begin
            errors++;
            $display("FAIL fp_first: sel=%b gid=%0d want 0010/1", sel_c, gid_c);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (sel_c !== 4'b0010) begin
                errors++;
                $display("FAIL fp_hold[%0d]: sel=%b want 0010", i, sel_c);
            end
        end
        req_c = 4'b1011;
        tick();
        checks++;
        if (sel_c !== 4'b0001 || gid_c !== 2'd0) begin
            errors++;
            $display("FAIL fp_preempt: sel=%b gid=%0d want 0001/0", sel_c, gid_c);
        end
        req_c = 4'b1010;
        tick();
        checks++;
        if (sel_c !== 4'b0010) begin
            errors++;
            $display("FAIL fp_back1: sel=%b want 0010", sel_c);
        end
        req_c = 4'b1000;
        tick();
        checks++;
        if (sel_c !== 4'b1000 || gid_c !== 2'd3 || busy_c !== 1'b1) begin
            errors++;
            $display("FAIL fp_low: sel=%b gid=%0d busy=%b want 1000/3/1",
                     sel_c, gid_c, busy_c);
        end
        req_c = '0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_b = 4'b0010;
        tick();
        checks++;
        if (sel_b !== 4'b0010 || busy_b !== 1'b1) begin
            errors++;
            $display("FAIL b2b_own1: sel=%b busy=%b want 0010/1", sel_b, busy_b);
        end
        req_b = 4'b0100;
        tick();
        checks++;
        if (sel_b !== 4'b0100 || gid_b !== 2'd2 || busy_b !== 1'b1) begin
            errors++;
            $display("FAIL b2b_handoff: sel=%b gid=%0d busy=%b want 0100/2/1",
                     sel_b, gid_b, busy_b);
        end
        req_b = '0;
        tick();
        checks++;
        if (sel_b !== 4'b0001 || gid_b !== 2'd0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL b2b_park: sel=%b gid=%0d busy=%b want 0001/0/0",
                     sel_b, gid_b, busy_b);
        end
        req_b = 4'b0001;
        #1;
        checks++;
        if (rdy_b !== 4'b0001) begin
            errors++;
            $display("FAIL park_rdy: rdy=%b want 0001", rdy_b);
        end
        tick();
        checks++;
        if (sel_b !== 4'b0001 || busy_b !== 1'b1) begin
            errors++;
            $display("FAIL park_busy: sel=%b busy=%b want 0001/1", sel_b, busy_b);
        end
        req_b = '0;
    endtask

    initial begin
        n_reset = 1'b0;
        req_a = '0; req_b = '0; req_c = '0;
        ifrdy_a = 1'b1; ifrdy_b = 1'b1; ifrdy_c = 1'b1;
        test_reset();
        test_rr_fairness();
        test_starvation();
        test_wait_states();
        test_fixed_priority();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
